// File: rtl/gf180mcu_fd_io__bi_seq_pkg.sv
// Shared types and constants for the GF180MCU bidirectional pad sequencer.
// Optional glitch filter is selected with GF180MCU_FD_IO__BI_SEQ_GLITCH_FILTER_EN.
package gf180mcu_fd_io__bi_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2,
    ST_RECV  = 2'd3
  } state_e;

  // PULL_MODE encodings; 2'b11 behaves as no pull
  localparam logic [1:0] PULL_NONE = 2'b00;
  localparam logic [1:0] PULL_UP   = 2'b01;
  localparam logic [1:0] PULL_DOWN = 2'b10;

  // Phase counter width: covers BIT_CYCLES up to 255 and the longest receive window
  localparam int unsigned CNT_W = 8;

  // Legal parameter ranges
  localparam int unsigned BIT_CYCLES_MIN  = 2;
  localparam int unsigned BIT_CYCLES_MAX  = 255;
  localparam int unsigned TURN_CYCLES_MIN = 1;
  localparam int unsigned TURN_CYCLES_MAX = 15;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned FILT_LEN_MIN    = 2;
  localparam int unsigned FILT_LEN_MAX    = 8;

  // Map PULL_MODE to {pu, pd}; never returns both set
  function automatic logic [1:0] pull_decode(input logic [1:0] mode);
    logic [1:0] pupd;
    pupd = 2'b00;
    case (mode)
      PULL_UP:   pupd = 2'b10;
      PULL_DOWN: pupd = 2'b01;
      default:   pupd = 2'b00;
    endcase
    return pupd;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_io__bi_seq_sync.sv
// PAD_Y synchronizer with optional glitch filter.
// Filter is built only when GF180MCU_FD_IO__BI_SEQ_GLITCH_FILTER_EN is defined.
module gf180mcu_fd_io__bi_seq_sync
  import gf180mcu_fd_io__bi_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
    $error("FILT_LEN out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw pad value into the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Synchronizer flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef GF180MCU_FD_IO__BI_SEQ_GLITCH_FILTER_EN
  logic [FILT_LEN-1:0] hist_q;
  logic [FILT_LEN-1:0] hist_d;
  logic                held_q;
  logic                held_d;

  // Held value changes only when the last FILT_LEN samples all agree
  always_comb begin
    hist_d = {hist_q[FILT_LEN-2:0], sync_q[SYNC_STAGES-1]};
    held_d = held_q;
    if (&hist_d) begin
      held_d = 1'b1;
    end else if (~|hist_d) begin
      held_d = 1'b0;
    end
  end

  // Filter history and held value
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      held_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      held_q <= held_d;
    end
  end

  assign q_o = held_q;
`else
  assign q_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gf180mcu_fd_io__bi_seq.sv
// Sequencer for a GF180MCU bidirectional pad: drives bits, turns the pad
// around, and takes single synchronized samples of PAD_Y.
// Define GF180MCU_FD_IO__BI_SEQ_GLITCH_FILTER_EN to add the PAD_Y glitch filter.
module gf180mcu_fd_io__bi_seq
  import gf180mcu_fd_io__bi_seq_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = 4,
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_VALID,
  input  logic       TX_DATA,
  output logic       TX_READY,
  input  logic       RX_REQ,
  output logic       RX_VALID,
  output logic       RX_DATA,
  input  logic [1:0] PULL_MODE,
  input  logic       SLEW,
  input  logic       SCHMITT,
  output logic       PAD_A,
  output logic       PAD_OE,
  output logic       PAD_IE,
  output logic       PAD_PU,
  output logic       PAD_PD,
  output logic       PAD_SL,
  output logic       PAD_CS,
  input  logic       PAD_Y,
  output logic       BUSY
);

  if (BIT_CYCLES < BIT_CYCLES_MIN || BIT_CYCLES > BIT_CYCLES_MAX) begin : g_bad_bit
    $error("BIT_CYCLES out of range");
  end
  if (TURN_CYCLES < TURN_CYCLES_MIN || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_turn
    $error("TURN_CYCLES out of range");
  end

  // Receive window length measured from RECV entry to the RX_VALID cycle
`ifdef GF180MCU_FD_IO__BI_SEQ_GLITCH_FILTER_EN
  localparam int unsigned RX_LAT = SYNC_STAGES + FILT_LEN + 1;
`else
  localparam int unsigned RX_LAT = SYNC_STAGES + 1;
`endif

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_LAT);
  localparam logic [CNT_W-1:0] RX_CAP    = CNT_W'(RX_LAT - 1);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic tx_ready_q, tx_ready_d;
  logic rx_valid_q, rx_valid_d;
  logic rx_data_q,  rx_data_d;
  logic pad_a_q,    pad_a_d;
  logic pad_oe_q,   pad_oe_d;
  logic pad_ie_q,   pad_ie_d;
  logic pad_pu_q,   pad_pu_d;
  logic pad_pd_q,   pad_pd_d;
  logic pad_sl_q,   pad_sl_d;
  logic pad_cs_q,   pad_cs_d;
  logic busy_q,     busy_d;

  logic       accept_c;
  logic       sync_y_c;
  logic [1:0] pull_c;

  assign accept_c = TX_VALID && tx_ready_q;
  assign pull_c   = pull_decode(PULL_MODE);

  gf180mcu_fd_io__bi_seq_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d_i (PAD_Y),
    .q_o (sync_y_c)
  );

  // State and phase counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; transmit has priority over a receive request in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept_c) begin
          state_d = ST_DRIVE;
        end else if (RX_REQ && !TX_VALID) begin
          state_d = ST_RECV;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!accept_c) begin
            state_d = ST_TURN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RECV: begin
        if (cnt_q == RX_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    pad_a_d    = pad_a_q;
    pad_oe_d   = 1'b0;
    pad_ie_d   = 1'b0;
    pad_pu_d   = 1'b0;
    pad_pd_d   = 1'b0;
    busy_d     = 1'b0;
    pad_sl_d   = SLEW;
    pad_cs_d   = SCHMITT;
    case (state_d)
      ST_IDLE: begin
        tx_ready_d = 1'b1;
        pad_pu_d   = pull_c[1];
        pad_pd_d   = pull_c[0];
      end
      ST_DRIVE: begin
        pad_oe_d   = 1'b1;
        busy_d     = 1'b1;
        tx_ready_d = (cnt_d == BIT_LAST);
      end
      ST_TURN: begin
        busy_d = 1'b1;
      end
      ST_RECV: begin
        pad_ie_d   = 1'b1;
        busy_d     = 1'b1;
        pad_pu_d   = pull_c[1];
        pad_pd_d   = pull_c[0];
        rx_valid_d = (cnt_d == RX_LAST);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
    if (accept_c) begin
      pad_a_d = TX_DATA;
    end
    if (state_q == ST_RECV && cnt_q == RX_CAP) begin
      rx_data_d = sync_y_c;
    end
  end

  // Output register; reset clears every output including TX_READY
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 1'b0;
      pad_a_q    <= 1'b0;
      pad_oe_q   <= 1'b0;
      pad_ie_q   <= 1'b0;
      pad_pu_q   <= 1'b0;
      pad_pd_q   <= 1'b0;
      pad_sl_q   <= 1'b0;
      pad_cs_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      pad_a_q    <= pad_a_d;
      pad_oe_q   <= pad_oe_d;
      pad_ie_q   <= pad_ie_d;
      pad_pu_q   <= pad_pu_d;
      pad_pd_q   <= pad_pd_d;
      pad_sl_q   <= pad_sl_d;
      pad_cs_q   <= pad_cs_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_READY = tx_ready_q;
  assign RX_VALID = rx_valid_q;
  assign RX_DATA  = rx_data_q;
  assign PAD_A    = pad_a_q;
  assign PAD_OE   = pad_oe_q;
  assign PAD_IE   = pad_ie_q;
  assign PAD_PU   = pad_pu_q;
  assign PAD_PD   = pad_pd_q;
  assign PAD_SL   = pad_sl_q;
  assign PAD_CS   = pad_cs_q;
  assign BUSY     = busy_q;

endmodule
